// File: rtl/mac_pkg.sv
// mac_pkg
// Shared definitions for the MAC control sequencer: FSM state encoding,
// MAC instruction register (MIR) field widths, address stride and the
// packed MIR view {valid, addr, count}.
package mac_pkg;

   localparam int MIR_ADDR_W = 21;
   localparam int MIR_CNT_W  = 4;
   localparam int MIR_W      = 1 + MIR_ADDR_W + MIR_CNT_W;
   localparam int MAC_STRIDE = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ACC   = 3'd3,
      ST_DONE  = 3'd4
   } mac_state_e;

   typedef struct packed {
      logic                  valid;
      logic [MIR_ADDR_W-1:0] addr;
      logic [MIR_CNT_W-1:0]  count;
   } mir_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if
// Bundles the three handshakes of the MAC sequencer:
//   cmd_* : command from the issuing core stage (valid/ready)
//   mem_* : single-outstanding read port (req/gnt, then rvalid/rdata)
//   res_* : accumulated result back to the core stage (valid/ready)
// modport master : the sequencer side
// modport slave  : the core stage / memory side
interface mac_sequencer_if
   import mac_pkg::*;
#(
   parameter int OP_W   = 16,
   parameter int ACC_W  = 40,
   parameter int ADDR_W = MIR_ADDR_W,
   parameter int CNT_W  = MIR_CNT_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [CNT_W-1:0]  cmd_count;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [2*OP_W-1:0] mem_rdata;

   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_data;

   modport master (
      input  cmd_valid, cmd_addr, cmd_count,
      output cmd_ready,
      output mem_req, mem_addr,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output res_valid, res_data,
      input  res_ready
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_count,
      input  cmd_ready,
      input  mem_req, mem_addr,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  res_valid, res_data,
      output res_ready
   );

endinterface

// File: rtl/mac_ir_step.sv
// mac_ir_step
// Combinational next value of the MAC instruction register.
//   addr_cur : current address field
//   cnt_cur  : current count field
//   mir_nxt  : {1, addr_cur+MAC_STRIDE, cnt_cur-1}, or all-zero if cnt_cur==0
// The zero case keeps the count from ever wrapping below zero.
module mac_ir_step
   import mac_pkg::*;
#(
   parameter int ADDR_W = MIR_ADDR_W,
   parameter int CNT_W  = MIR_CNT_W
) (
   input  logic [ADDR_W-1:0]     addr_cur,
   input  logic [CNT_W-1:0]      cnt_cur,
   output logic [ADDR_W+CNT_W:0] mir_nxt
);

   always_comb begin
      mir_nxt = '0;
      if (cnt_cur != '0) begin
         mir_nxt = {1'b1, addr_cur + ADDR_W'(MAC_STRIDE), cnt_cur - CNT_W'(1)};
      end
   end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer
// Walks the MAC instruction register through one command: for each element
// it reads an operand pair, accumulates a*b, steps the address by 8 and
// decrements the count, then hands the sum back over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cmd/mem/res handshakes (mac_sequencer_if.master)
//   busy       : high in any state other than IDLE
//   mir        : live MAC instruction register {valid, addr, count}
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// ISSUE | mem_req high at mir.addr until granted
// WAIT  | read granted, waiting for mem_rvalid
// ACC   | accumulate latched pair, step the MIR
// DONE  | res_valid high with the sum until res_ready
module mac_sequencer
   import mac_pkg::*;
#(
   parameter int OP_W   = 16,
   parameter int ACC_W  = 40,
   parameter int ADDR_W = MIR_ADDR_W,
   parameter int CNT_W  = MIR_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mac_sequencer_if.master       bus,
   output logic                  busy,
   output logic [ADDR_W+CNT_W:0] mir
);

   localparam int MIR_LEN = 1 + ADDR_W + CNT_W;
   localparam int PROD_W  = 2 * OP_W;

   mac_state_e state_q, state_d;
   logic [MIR_LEN-1:0] mir_q, mir_d, mir_step;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [OP_W-1:0]    op_a_q, op_a_d;
   logic [OP_W-1:0]    op_b_q, op_b_d;
   logic               ready_en_q, ready_en_d;

   logic [ADDR_W-1:0]        mir_addr;
   logic [CNT_W-1:0]         mir_cnt;
   logic signed [PROD_W-1:0] prod;

   assign mir_addr = mir_q[CNT_W +: ADDR_W];
   assign mir_cnt  = mir_q[CNT_W-1:0];
   assign prod     = $signed(op_a_q) * $signed(op_b_q);

   mac_ir_step #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_ir_step (
      .addr_cur (mir_addr),
      .cnt_cur  (mir_cnt),
      .mir_nxt  (mir_step)
   );

   // cmd_ready must read 0 while reset is held even though the state is
   // already IDLE; this flop lets it rise on the first edge after release.
   always_comb begin
      ready_en_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      mir_d   = mir_q;
      acc_d   = acc_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && ready_en_q) begin
               mir_d   = {1'b1, bus.cmd_addr, bus.cmd_count};
               acc_d   = '0;
               state_d = (bus.cmd_count != '0) ? ST_ISSUE : ST_DONE;
            end
         end
         ST_ISSUE: begin
            if (bus.mem_gnt) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mem_rvalid) begin
               op_a_d  = bus.mem_rdata[OP_W-1:0];
               op_b_d  = bus.mem_rdata[PROD_W-1:OP_W];
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            if (mir_step[CNT_W-1:0] == '0) begin
               mir_d   = '0;
               state_d = ST_DONE;
            end else begin
               mir_d   = mir_step;
               state_d = ST_ISSUE;
            end
         end
         ST_DONE: begin
            if (bus.res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mir_q      <= '0;
         acc_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mir_q      <= mir_d;
         acc_q      <= acc_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         ready_en_q <= ready_en_d;
      end
   end

   assign bus.cmd_ready = (state_q == ST_IDLE) && ready_en_q;
   assign bus.mem_req   = (state_q == ST_ISSUE);
   assign bus.mem_addr  = mir_addr;
   assign bus.res_valid = (state_q == ST_DONE);
   assign bus.res_data  = acc_q;
   assign busy          = (state_q != ST_IDLE);
   assign mir           = mir_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
// Directed bench for mac_sequencer: a small memory responder with
// configurable grant delay feeds operand pairs; every check goes through chk.
module tb_mac_sequencer;
   import mac_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             busy;
   logic [MIR_W-1:0] mir;
   int               checks = 0;
   int               failures = 0;
   mir_t             m_exp;

   mac_sequencer_if #(.OP_W(16), .ACC_W(40), .ADDR_W(21), .CNT_W(4)) bus ();

   mac_sequencer #(.OP_W(16), .ACC_W(40), .ADDR_W(21), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master),
      .busy  (busy),
      .mir   (mir)
   );

   always #5 clk = ~clk;

   // memory responder
   int          gnt_delay = 0;
   int          wait_cnt = 0;
   bit          rv_pend = 1'b0;
   bit          stray_en = 1'b0;
   bit          late_rv = 1'b0;
   bit          req_seen = 1'b0;
   logic [31:0] rd_pend = '0;
   logic [31:0] pairs[$];
   logic [20:0] addr_log[$];

   always @(negedge clk) begin
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      if (!rst_n) begin
         rv_pend  = 1'b0;
         wait_cnt = 0;
      end else begin
         if (rv_pend) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rd_pend;
            rv_pend        = 1'b0;
         end else if (late_rv) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h7FFF_7FFF;
            late_rv        = 1'b0;
         end
         if (bus.mem_req) begin
            req_seen = 1'b1;
            if (wait_cnt >= gnt_delay) begin
               bus.mem_gnt = 1'b1;
               wait_cnt    = 0;
               addr_log.push_back(bus.mem_addr);
               rd_pend = (pairs.size() > 0) ? pairs.pop_front() : 32'h0;
               rv_pend = 1'b1;
            end else begin
               wait_cnt++;
               if (stray_en) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = 32'h7FFF_7FFF;
               end
            end
         end
      end
   end

   function automatic logic [31:0] pr(input int a, input int b);
      return {b[15:0], a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // call at a negedge in IDLE; returns at the negedge of cycle 1
   task automatic send_cmd(input logic [20:0] a, input logic [3:0] c);
      chk("cmd_ready_pre", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = a;
      bus.cmd_count = c;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_res(input int start, input int max, output int cyc);
      cyc = start;
      while (!bus.res_valid && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
      chk("res_valid_seen", 64'(bus.res_valid), 64'd1);
   endtask

   task automatic take_res();
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("res_dropped", 64'(bus.res_valid), 64'd0);
      chk("back_idle", 64'(bus.cmd_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_count = '0;
      bus.res_ready = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_mir", 64'(mir), 64'd0);
      #2 rst_n = 1'b1;
      #1 chk("rel_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      @(negedge clk);
      chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

      // basic dot product: 2*3 + 4*5 + (-1)*7 = 19
      pairs = '{pr(2, 3), pr(4, 5), pr(-1, 7)};
      addr_log.delete();
      send_cmd(21'h100, 4'd3);
      m_exp = '{valid: 1'b1, addr: 21'h100, count: 4'd3};
      chk("t1_mir_load", 64'(mir), 64'(m_exp));
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_req_c1", 64'(bus.mem_req), 64'd1);
      wait_res(1, 40, cyc);
      chk("t1_cycle", 64'(cyc), 64'd10);
      chk("t1_data", 64'(bus.res_data), 64'd19);
      chk("t1_nreq", 64'(addr_log.size()), 64'd3);
      chk("t1_addr0", 64'(addr_log[0]), 64'h100);
      chk("t1_addr1", 64'(addr_log[1]), 64'h108);
      chk("t1_addr2", 64'(addr_log[2]), 64'h110);
      chk("t1_mir_done", 64'(mir), 64'd0);
      take_res();

      // count 0
      req_seen = 1'b0;
      addr_log.delete();
      send_cmd(21'h055, 4'd0);
      wait_res(1, 10, cyc);
      chk("t2_cycle", 64'(cyc), 64'd1);
      chk("t2_data", 64'(bus.res_data), 64'd0);
      chk("t2_no_req", 64'(req_seen), 64'd0);
      take_res();

      // address wrap
      pairs = '{pr(1, 1), pr(1, 1)};
      addr_log.delete();
      send_cmd(21'h1FFFF8, 4'd2);
      wait_res(1, 30, cyc);
      chk("t3_cycle", 64'(cyc), 64'd7);
      chk("t3_data", 64'(bus.res_data), 64'd2);
      chk("t3_addr0", 64'(addr_log[0]), 64'h1FFFF8);
      chk("t3_addr1", 64'(addr_log[1]), 64'h000000);
      take_res();

      // backpressure: grant after 3 extra cycles with stray rvalid in ISSUE,
      // then result held for 5 cycles while a command is offered
      pairs = '{pr(-3, 5)};
      addr_log.delete();
      gnt_delay = 3;
      stray_en  = 1'b1;
      send_cmd(21'h040, 4'd1);
      for (int i = 0; i < 3; i++) begin
         chk("t4_req_hold", 64'(bus.mem_req), 64'd1);
         chk("t4_addr_hold", 64'(bus.mem_addr), 64'h040);
         @(negedge clk);
      end
      chk("t4_req_c4", 64'(bus.mem_req), 64'd1);
      stray_en  = 1'b0;
      gnt_delay = 0;
      wait_res(4, 30, cyc);
      chk("t4_cycle", 64'(cyc), 64'd7);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 21'h0;
      bus.cmd_count = 4'd0;
      for (int i = 0; i < 5; i++) begin
         chk("t4_res_hold", 64'(bus.res_valid), 64'd1);
         chk("t4_data_hold", 64'(bus.res_data), 64'h0000_00FF_FFFF_FFF1);
         chk("t4_cmd_blocked", 64'(bus.cmd_ready), 64'd0);
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      chk("t4_sim_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("t4_after_done", 64'(bus.res_valid), 64'd0);
      chk("t4_idle_ready", 64'(bus.cmd_ready), 64'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("t4_next_cmd", 64'(bus.res_valid), 64'd1);
      chk("t4_next_data", 64'(bus.res_data), 64'd0);
      take_res();

      // magnitude: 15 * (-32768 * -32768) = 15 * 2^30
      pairs.delete();
      for (int i = 0; i < 15; i++) pairs.push_back(pr(-32768, -32768));
      addr_log.delete();
      send_cmd(21'h200, 4'd15);
      wait_res(1, 60, cyc);
      chk("t5_cycle", 64'(cyc), 64'd46);
      chk("t5_data", 64'(bus.res_data), 64'h3_C000_0000);
      take_res();

      // reset in WAIT of element 2
      pairs = '{pr(1, 1), pr(1, 1), pr(1, 1)};
      addr_log.delete();
      send_cmd(21'h300, 4'd3);
      repeat (4) @(negedge clk);
      m_exp = '{valid: 1'b1, addr: 21'h308, count: 4'd2};
      chk("t6_mir_wait2", 64'(mir), 64'(m_exp));
      chk("t6_wait_noreq", 64'(bus.mem_req), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("t6_mir", 64'(mir), 64'd0);
      chk("t6_res_data", 64'(bus.res_data), 64'd0);
      chk("t6_res_valid", 64'(bus.res_valid), 64'd0);
      chk("t6_mem_addr", 64'(bus.mem_addr), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      late_rv = 1'b1;
      @(negedge clk);
      chk("t6_idle_late_rv", 64'(busy), 64'd0);
      @(negedge clk);
      chk("t6_still_idle", 64'(busy), 64'd0);
      chk("t6_ready", 64'(bus.cmd_ready), 64'd1);
      pairs.delete();
      pairs.push_back(pr(3, 3));
      addr_log.delete();
      send_cmd(21'h010, 4'd1);
      wait_res(1, 20, cyc);
      chk("t6_cycle", 64'(cyc), 64'd4);
      chk("t6_data", 64'(bus.res_data), 64'd9);
      take_res();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control sequencer for the MAC datapath. It accepts one MAC command (21-bit base address, 4-bit element count) and walks the MAC instruction register through its steps. At each step it fetches one operand pair from memory at the current address, multiplies and accumulates it, then advances the address by 8 and decrements the count. When the count reaches zero it returns the accumulated result to the issuing core stage over a valid/ready handshake.

## Interface
- `OP_W`, default 16: signed operand width; each memory word carries two operands.
- `ACC_W`, default 40: signed accumulator width.
- `ADDR_W`, default 21: address field width of the MAC instruction register.
- `CNT_W`, default 4: count field width of the MAC instruction register.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command; high only in IDLE.
- `cmd_addr`  in  ADDR_W  base address of the first element.
- `cmd_count`  in  CNT_W  number of elements, 0..15.
- `mem_req`  out  1  read request.
- `mem_addr`  out  ADDR_W  read address; stable while `mem_req` is high.
- `mem_gnt`  in  1  request accepted in this cycle.
- `mem_rvalid`  in  1  read data returned in this cycle.
- `mem_rdata`  in  2*OP_W  operand pair: operand a in [OP_W-1:0], operand b in [2*OP_W-1:OP_W].
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  ACC_W  signed accumulated sum.
- `busy`  out  1  high in any state other than IDLE.
- `mir`  out  1+ADDR_W+CNT_W  live MAC instruction register, packed as {valid, addr, count}.

## Operation
- States are IDLE, ISSUE, WAIT, ACC and DONE.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`:
  - load `mir` = {1, `cmd_addr`, `cmd_count`} and clear the accumulator.
  - go to ISSUE if count is nonzero; go to DONE if count is 0.
- **ISSUE:** `mem_req`=1 with `mem_addr`=`mir.addr`. Go to WAIT on `mem_gnt`; otherwise hold the request.
- **WAIT:** `mem_rvalid` is sampled only in this state and ignored elsewhere. On `mem_rvalid`:
  - latch the operand pair.
  - go to ACC.
- **ACC:**
  - acc += sign-extended (a*b), with a 2*OP_W signed product and accumulation wrapping modulo 2^ACC_W.
  - Step the register: addr = (addr+8) mod 2^ADDR_W, count = count-1.
  - If the new count is 0, clear `mir` to all-zero and go to DONE; otherwise go to ISSUE.
- **DONE:** `res_valid`=1 and `res_data`=acc, held stable until `res_ready`, then go to IDLE.
- Only one memory request is ever outstanding.
- No command is accepted outside IDLE.

## Timing
- Reset values: all outputs are 0 (`cmd_ready`=0 during reset); the accumulator is 0 and the state is IDLE.
  - `cmd_ready` rises combinationally from IDLE on the first clock after release.
- **Reset mid-operation:** returns immediately to IDLE. An in-flight read is abandoned; its late `mem_rvalid` is ignored.
- **Zero-wait memory** (`mem_gnt` in the first ISSUE cycle, `mem_rvalid` one cycle later), command accepted at edge 0:
  - `mem_req` is high in cycle 1.
  - Each element costs 3 cycles.
  - `res_valid` rises in cycle 3N+1.
- **Count 0:** `res_valid` in cycle 1 with `res_data`=0; `mem_req` is never raised.
- **Address wrap-around:** 0x1FFFF8 + 8 = 0x000000.
- The count never underflows: the step is applied only when count ≥ 1.
- **Simultaneous `res_ready` and `cmd_valid` in DONE:** the command is not accepted (`cmd_ready`=0). It is accepted no earlier than the following IDLE cycle.

## Structure
- A shared package `mac_pkg` holds:
  - the state enum.
  - the MIR field widths.
  - `MAC_STRIDE`=8.
  - the MIR packing/typedef {valid, addr, count}.
- One combinational sub-module, `mac_ir_step`, computes the next MIR from the current one: {1, addr+8, count-1}, or all-zero when count is 0.
- The sequencer instantiates `mac_ir_step` and applies its output in ACC.

## Test plan
- **Basic dot product:** base 0x100, count 3, pairs (2,3), (4,5), (-1,7), zero-wait memory.
  - Requests go to 0x100, 0x108 and 0x110.
  - `res_data`=19 and `res_valid` at cycle 10.
- **Count 0:** `res_valid` at cycle 1 with `res_data`=0; no `mem_req` pulse.
- **Wrap-around:** base 0x1FFFF8, count 2 → `mem_addr` is 0x1FFFF8 then 0x000000.
- **Backpressure:**
  - `mem_gnt` delayed 3 cycles: `mem_req`/`mem_addr` stay stable.
  - `res_ready` low for 5 cycles: `res_data` is held and `cmd_ready`=0 throughout.
  - A stray `mem_rvalid` during ISSUE is ignored.
- **Magnitude:** count 15, all pairs (-32768,-32768) → `res_data` = 15·2^30 = 0x3C0000000, no overflow.
- **Reset mid-operation:** `rst_n` pulled low in WAIT of element 2.
  - All outputs go to 0 asynchronously.
  - After release the block is in IDLE; a fresh count-1 command with pair (3,3) yields 9.
